// File: rtl/word_gather8x16_pkg.sv
// Shared constants and state encoding for the 8x16 word gatherer.
package word_gather8x16_pkg;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 8;
    localparam int COUNT_W = 4;

    // All-ones is the identity for AND, so padded slots do not disturb the reduction.
    localparam logic [WIDTH-1:0] PAD_WORD = 16'hFFFF;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/word_gather8x16_gather_slot16.sv
// One bundle slot: a word register that loads either the incoming word or the pad word.
module gather_slot16
    import word_gather8x16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic             pad_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] slot_q;
    logic [WIDTH-1:0] slot_d;

    assign slot_d = pad_i ? PAD_WORD : data_i;
    assign q_o    = slot_q;

    // Slot storage; contents persist across bundles until overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (we_i) begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/word_gather8x16.sv
// Packs eight serially received 16-bit words into a registered 128-bit bundle,
// with an early flush that pads the remaining slots with all-ones.
module word_gather8x16 #(
    parameter int WIDTH = word_gather8x16_pkg::WIDTH,
    parameter int DEPTH = word_gather8x16_pkg::DEPTH
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [WIDTH-1:0]                        in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    flush,
    output logic [WIDTH*DEPTH-1:0]                  out_bus,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [word_gather8x16_pkg::COUNT_W-1:0] count
);

    import word_gather8x16_pkg::*;

    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] cnt_acc;
    logic               accept;
    logic               do_flush;
    logic [DEPTH-1:0]   slot_we;
    logic [DEPTH-1:0]   slot_pad;

    assign count = count_q;

    // State and word-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state, handshake outputs and per-slot write/pad decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        do_flush  = 1'b0;
        cnt_acc   = count_q;
        slot_we   = '0;
        slot_pad  = '0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                cnt_acc  = count_q + COUNT_W'(accept);
                // An empty bundle ignores flush; a same-cycle 8th word fills it normally.
                do_flush = flush && (count_q != '0) && (cnt_acc != FULL);
                for (int k = 0; k < DEPTH; k++) begin
                    if (accept && (count_q == COUNT_W'(k))) begin
                        slot_we[k] = 1'b1;
                    end else if (do_flush && (COUNT_W'(k) >= cnt_acc)) begin
                        slot_we[k]  = 1'b1;
                        slot_pad[k] = 1'b1;
                    end
                end
                if ((cnt_acc == FULL) || do_flush) begin
                    state_d = HOLD;
                    count_d = FULL;
                end else begin
                    count_d = cnt_acc;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
                count_d = '0;
            end
        endcase
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        gather_slot16 u_slot (
            .clk    (clk),
            .rst    (rst),
            .we_i   (slot_we[g]),
            .pad_i  (slot_pad[g]),
            .data_i (in_data),
            .q_o    (out_bus[g*WIDTH +: WIDTH])
        );
    end

endmodule
